count_seq_ctrl: RTL and testbench
=================================

COUNT_SEQ_CTRL -- requirements
Module: count_seq_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000: clear_btn stability window in clk cycles (5 ms at 50 MHz).
REQ-002 Parameter MAX_COUNT, default 9999: highest count value; SHALL be at most 9999.
REQ-003 Port clk, input, 1: the single clock; all state SHALL be on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port tick, input, 1: one-cycle count-enable pulse from the 10 Hz divider domain, already synchronous to clk.
REQ-006 Port dir, input, 1: count direction, 1 = up, 0 = down; sampled only on tick cycles.
REQ-007 Port clear_btn, input, 1: raw, asynchronous, bouncing push-button.
REQ-008 Port bin, output, 14: current binary count.
REQ-009 Port bcd, output, 16: four packed BCD digits of the last converted count, digit 0 in [3:0].
REQ-010 Port bcd_valid, output, 1: one-cycle pulse when bcd updates.
REQ-011 Port busy, output, 1: high while a conversion is in progress.

Function
REQ-012 clear_btn SHALL pass through a 2-flop synchronizer, then a debouncer that accepts a new level only after DEBOUNCE_CYCLES consecutive equal samples.
REQ-013 The rising edge of the debounced level SHALL produce a single one-cycle clear pulse.
REQ-014 Counter update precedence SHALL be clear, then tick, then hold.
- Clear: bin <= 0.
- Tick with dir=1: bin <= bin+1, wrapping MAX_COUNT -> 0.
- Tick with dir=0: bin <= bin-1, wrapping 0 -> MAX_COUNT.
REQ-015 Any cycle in which bin changes value SHALL set an internal pending flag; clear while bin=0 SHALL NOT set it.
REQ-016 The conversion FSM SHALL have states IDLE, LOAD, SHIFT and DONE.
REQ-017 IDLE -> LOAD when pending=1. LOAD SHALL snapshot bin, zero the BCD scratch register, clear pending and load the iteration counter with 14.
REQ-018 SHIFT SHALL run for exactly 14 cycles. Each cycle, every scratch digit >= 5 SHALL have 3 added, then {scratch, snapshot} SHALL shift left by one.
REQ-019 DONE SHALL copy scratch to bcd, pulse bcd_valid for one cycle, and return to IDLE.
REQ-020 Latency: bcd SHALL update and bcd_valid SHALL pulse exactly 16 cycles after the clk edge that changed bin (LOAD 1 + SHIFT 14 + DONE 1), when the FSM is IDLE at that edge.
REQ-021 busy SHALL be high in LOAD, SHIFT and DONE, and low in IDLE.
REQ-022 A bin change during a conversion SHALL NOT disturb the conversion in flight; it sets pending, and the FSM SHALL go DONE -> IDLE -> LOAD, so the final bcd always matches the final bin.
REQ-023 Any number of bin changes during one conversion SHALL collapse into one follow-up conversion.
REQ-024 bcd SHALL hold its value between DONE cycles; each nibble SHALL always be in 0..9.

Reset
REQ-025 While reset is asserted, these SHALL hold regardless of clk:
- bin=0, bcd=16'h0000, bcd_valid=0, busy=0
- FSM in IDLE, pending=0, debounced level=0, debounce counter=0
REQ-026 Reset asserted mid-conversion SHALL abort it without updating bcd.
REQ-027 The first tick after reset release SHALL be honoured in the cycle it arrives.

Structure
REQ-028 A shared package SHALL hold the FSM state enumeration (IDLE, LOAD, SHIFT, DONE), the BIN_W=14 and BCD_W=16 widths, and the iteration count 14.
REQ-029 The synchronizer, debouncer and edge detector SHALL form one sub-module, button_debounce (parameter DEBOUNCE_CYCLES; outputs level and rise pulse).
REQ-030 Counter and conversion FSM SHALL stay in count_seq_ctrl.

Verification (DEBOUNCE_CYCLES=8 in simulation)
REQ-031 Reset, then 3 ticks with dir=1 -> bin=3; bcd=16'h0003 with bcd_valid 16 cycles after the third tick.
REQ-032 bin=9999, one tick with dir=1 -> bin=0, bcd=16'h0000; then one tick with dir=0 -> bin=9999, bcd=16'h9999.
REQ-033 Set bin=1234, then 2 ticks with dir=1 spaced 3 cycles apart -> exactly two bcd_valid pulses, final bcd=16'h1236, no intermediate non-BCD nibble.
REQ-034 clear_btn bouncing 5 times at 2-cycle intervals, then held high 20 cycles -> exactly one clear; bin=0, bcd=16'h0000.
REQ-035 Clear and tick in the same cycle -> bin=0 (clear wins).
REQ-036 Reset asserted at SHIFT iteration 7 of converting 4321 -> bcd=16'h0000, busy=0 immediately; after release and one tick with dir=1 -> bcd=16'h0001.

Source files
------------

// File: rtl/count_seq_ctrl_pkg.sv
// Shared types and constants for the up/down counter with binary-to-BCD conversion.
//   conv_state_e : conversion FSM states
//   BIN_W/BCD_W  : binary count and packed-BCD widths
//   CONV_ITERS   : double-dabble iterations (one per binary bit)
package count_seq_ctrl_pkg;

  localparam int unsigned BIN_W      = 14;
  localparam int unsigned BCD_W      = 16;
  localparam int unsigned CONV_ITERS = 14;
  localparam int unsigned ITER_W     = 4;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StShift,
    StDone
  } conv_state_e;

  // Add 3 to every digit >= 5 so the following left shift carries correctly into the next digit.
  function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] s);
    logic [BCD_W-1:0] r;
    r = s;
    for (int i = 0; i < int'(BCD_W / 4); i++) begin
      if (s[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = s[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability debouncer and rising-edge detector.
//   clk, reset : clock and asynchronous active-high reset
//   btn        : raw asynchronous bouncing button
//   level      : debounced button level
//   rise       : one-cycle pulse on each rising edge of level
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic level,
  output logic rise
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            level_prev_q;

  // Count consecutive samples that disagree with the accepted level; any agreeing sample restarts.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CntMax) begin
        level_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q       <= '0;
      cnt_q        <= '0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
    end else begin
      sync_q       <= {sync_q[0], btn};
      cnt_q        <= cnt_d;
      level_q      <= level_d;
      level_prev_q <= level_q;
    end
  end

  assign level = level_q;
  assign rise  = level_q & ~level_prev_q;

endmodule

// File: rtl/count_seq_ctrl.sv
// Up/down decimal-range counter with debounced clear and a double-dabble BCD converter.
//   clk, reset : clock and asynchronous active-high reset
//   tick       : one-cycle count enable
//   dir        : 1 = count up, 0 = count down (sampled on tick)
//   clear_btn  : raw push-button, clears the count on its debounced rising edge
//   bin        : current binary count
//   bcd        : four packed BCD digits of the last converted count
//   bcd_valid  : one-cycle pulse when bcd updates
//   busy       : conversion in progress
module count_seq_ctrl
  import count_seq_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned MAX_COUNT       = 9999
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             dir,
  input  logic             clear_btn,
  output logic [BIN_W-1:0] bin,
  output logic [BCD_W-1:0] bcd,
  output logic             bcd_valid,
  output logic             busy
);

  localparam logic [BIN_W-1:0] MaxCnt = BIN_W'(MAX_COUNT);

  logic              clear_level;
  logic              clear_pulse;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic              bin_changed;
  logic              pending_q, pending_d;
  logic              load_conv;
  conv_state_e       state_q, state_d;
  logic [BIN_W-1:0]  snap_q, snap_d;
  logic [BCD_W-1:0]  scratch_q, scratch_d;
  logic [BCD_W-1:0]  scratch_adj;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic              bcd_valid_q, bcd_valid_d;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_clear_debounce (
    .clk  (clk),
    .reset(reset),
    .btn  (clear_btn),
    .level(clear_level),
    .rise (clear_pulse)
  );

  always_comb begin
    bin_d = bin_q;
    if (clear_pulse) begin
      bin_d = '0;
    end else if (tick) begin
      if (dir) begin
        bin_d = (bin_q == MaxCnt) ? '0 : bin_q + 1'b1;
      end else begin
        bin_d = (bin_q == '0) ? MaxCnt : bin_q - 1'b1;
      end
    end
  end

  assign bin_changed = (bin_d != bin_q);
  assign scratch_adj = bcd_adjust(scratch_q);

  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    scratch_d   = scratch_q;
    iter_d      = iter_q;
    bcd_d       = bcd_q;
    bcd_valid_d = 1'b0;
    load_conv   = 1'b0;
    unique case (state_q)
      // Leaving on the change itself (not the registered flag) keeps the 16-cycle latency.
      StIdle: begin
        if (pending_q || bin_changed) state_d = StLoad;
      end
      StLoad: begin
        snap_d    = bin_q;
        scratch_d = '0;
        iter_d    = ITER_W'(CONV_ITERS);
        load_conv = 1'b1;
        state_d   = StShift;
      end
      StShift: begin
        {scratch_d, snap_d} = {scratch_adj[BCD_W-2:0], snap_q, 1'b0};
        iter_d = iter_q - 1'b1;
        if (iter_q == ITER_W'(1)) state_d = StDone;
      end
      StDone: begin
        bcd_d       = scratch_q;
        bcd_valid_d = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // A change in the LOAD cycle lands after the snapshot, so setting must win over clearing.
  always_comb begin
    pending_d = pending_q;
    if (load_conv) pending_d = 1'b0;
    if (bin_changed) pending_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin_q       <= '0;
      pending_q   <= 1'b0;
      state_q     <= StIdle;
      snap_q      <= '0;
      scratch_q   <= '0;
      iter_q      <= '0;
      bcd_q       <= '0;
      bcd_valid_q <= 1'b0;
    end else begin
      bin_q       <= bin_d;
      pending_q   <= pending_d;
      state_q     <= state_d;
      snap_q      <= snap_d;
      scratch_q   <= scratch_d;
      iter_q      <= iter_d;
      bcd_q       <= bcd_d;
      bcd_valid_q <= bcd_valid_d;
    end
  end

  assign bin       = bin_q;
  assign bcd       = bcd_q;
  assign bcd_valid = bcd_valid_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Self-checking bench for count_seq_ctrl: expected BCD results are queued when a tick or clear
// is driven and compared when bcd_valid pulses.
module tb_count_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        tick;
  logic        dir;
  logic        clear_btn;
  logic [13:0] bin;
  logic [15:0] bcd;
  logic        bcd_valid;
  logic        busy;

  typedef struct {
    logic [15:0] bcd;
    int          due;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   nvalid = 0;
  bit   sb_on = 1'b0;
  int   model_bin = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  count_seq_ctrl #(
    .DEBOUNCE_CYCLES(8),
    .MAX_COUNT      (9999)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .dir      (dir),
    .clear_btn(clear_btn),
    .bin      (bin),
    .bcd      (bcd),
    .bcd_valid(bcd_valid),
    .busy     (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d (0x%0h) want=%0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int n);
    logic [15:0] r;
    int          v;
    r = '0;
    v = n;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic nib_ok(input logic [15:0] v);
    for (int i = 0; i < 4; i++) begin
      if (v[4*i +: 4] > 4'd9) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int step_model(input int b, input logic d);
    if (d) return (b == 9999) ? 0 : b + 1;
    return (b == 0) ? 9999 : b - 1;
  endfunction

  // Scoreboard consumer.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && bcd_valid) begin
      nvalid++;
      check_eq("bcd_nibbles", 32'(nib_ok(bcd)), 32'd1);
      if (sb_on) begin
        if (sb_q.size() == 0) begin
          check_eq("extra_valid", 32'(sb_q.size()), 32'd1);
        end else begin
          e = sb_q.pop_front();
          check_eq("bcd", 32'(bcd), 32'(e.bcd));
          if (e.due >= 0) check_eq("latency", 32'(cyc), 32'(e.due));
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at #1 after an edge; the tick is taken on the next edge.
  task automatic tick_once(input logic d, input bit push, input bit timed);
    exp_t e;
    tick = 1'b1;
    dir  = d;
    @(posedge clk);
    #1;
    tick = 1'b0;
    model_bin = step_model(model_bin, d);
    if (push) begin
      e.bcd = to_bcd(model_bin);
      e.due = timed ? cyc + 16 : -1;
      sb_q.push_back(e);
    end
  endtask

  task automatic bulk(input logic d, input int n);
    tick = 1'b1;
    dir  = d;
    repeat (n) @(posedge clk);
    #1;
    tick = 1'b0;
    for (int i = 0; i < n; i++) model_bin = step_model(model_bin, d);
  endtask

  task automatic settle(input string tag);
    int idle;
    int n;
    idle = 0;
    n = 0;
    while (idle < 3 && n < 400) begin
      @(negedge clk);
      n++;
      if (!busy) idle++;
      else idle = 0;
    end
    if (idle < 3) check_eq({tag, "_settle_timeout"}, 32'(idle), 32'd3);
    check_eq({tag, "_bin"}, 32'(bin), 32'(model_bin));
    check_eq({tag, "_bcd"}, 32'(bcd), 32'(to_bcd(model_bin)));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   v0;
    int   prev;
    bit   found;
    exp_t e;

    reset = 1'b1;
    tick = 1'b0;
    dir = 1'b1;
    clear_btn = 1'b0;
    #12;
    check_eq("rst_bin", 32'(bin), 32'd0);
    check_eq("rst_bcd", 32'(bcd), 32'h0);
    check_eq("rst_valid", 32'(bcd_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    cycles(3);
    reset = 1'b0;

    // Three spaced up-ticks, first one right after reset release.
    sb_on = 1'b1;
    tick_once(1'b1, 1'b1, 1'b1);
    check_eq("first_tick_bin", 32'(bin), 32'd1);
    cycles(20);
    tick_once(1'b1, 1'b1, 1'b1);
    cycles(20);
    tick_once(1'b1, 1'b1, 1'b1);
    check_eq("three_ticks_bin", 32'(bin), 32'd3);
    cycles(20);
    settle("up3");

    // Wrap in both directions.
    sb_on = 1'b0;
    bulk(1'b0, 4);
    settle("to9999");
    sb_on = 1'b1;
    tick_once(1'b1, 1'b1, 1'b1);
    check_eq("wrap_up_bin", 32'(bin), 32'd0);
    cycles(20);
    tick_once(1'b0, 1'b1, 1'b1);
    check_eq("wrap_down_bin", 32'(bin), 32'd9999);
    cycles(20);
    settle("wrap");

    // Tick during a conversion collapses into one follow-up conversion.
    sb_on = 1'b0;
    bulk(1'b1, 1235);
    settle("to1234");
    sb_on = 1'b1;
    v0 = nvalid;
    tick_once(1'b1, 1'b1, 1'b1);
    cycles(2);
    tick_once(1'b1, 1'b1, 1'b0);
    settle("overlap");
    check_eq("overlap_pulses", 32'(nvalid - v0), 32'd2);

    // Bouncing clear button yields exactly one clear.
    v0 = nvalid;
    e.bcd = 16'h0000;
    e.due = -1;
    sb_q.push_back(e);
    model_bin = 0;
    for (int i = 0; i < 5; i++) begin
      clear_btn = 1'b1;
      cycles(2);
      clear_btn = 1'b0;
      cycles(2);
    end
    clear_btn = 1'b1;
    cycles(20);
    clear_btn = 1'b0;
    cycles(20);
    settle("bounce");
    check_eq("bounce_pulses", 32'(nvalid - v0), 32'd1);

    // Clear arrives while tick is held high: clear must win.
    sb_on = 1'b0;
    clear_btn = 1'b1;
    tick = 1'b1;
    dir = 1'b1;
    prev = int'(bin);
    found = 1'b0;
    for (int n = 0; n < 60 && !found; n++) begin
      @(negedge clk);
      if (int'(bin) < prev) begin
        found = 1'b1;
        check_eq("clear_wins", 32'(bin), 32'd0);
        tick = 1'b0;
      end else begin
        prev = int'(bin);
      end
    end
    tick = 1'b0;
    if (!found) check_eq("clear_seen", 32'(found), 32'd1);
    model_bin = 0;
    @(posedge clk);
    #1;
    clear_btn = 1'b0;
    cycles(20);
    settle("clr_tick");

    // Reset in the middle of converting 4321.
    bulk(1'b1, 4320);
    settle("to4320");
    tick_once(1'b1, 1'b0, 1'b0);
    cycles(8);
    reset = 1'b1;
    #1;
    check_eq("abort_bcd", 32'(bcd), 32'h0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_bin", 32'(bin), 32'd0);
    check_eq("abort_valid", 32'(bcd_valid), 32'd0);
    cycles(2);
    reset = 1'b0;
    model_bin = 0;
    cycles(20);
    check_eq("post_reset_bcd", 32'(bcd), 32'h0);
    sb_on = 1'b1;
    tick_once(1'b1, 1'b1, 1'b1);
    cycles(20);
    settle("after_abort");

    check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
